// File: rtl/order_msg_dispatcher.sv
// order_msg_dispatcher: assembles byte-serial order messages, validates them and dispatches to the add / cancel engines
module order_msg_dispatcher #(
  parameter int TIMEOUT = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        add_start,
  output logic        add_side,
  output logic [47:0] add_order,
  input  logic        add_done,
  input  logic [15:0] add_success,
  output logic        cxl_start,
  output logic [15:0] cxl_id,
  input  logic        cxl_done,
  input  logic [15:0] cxl_success,
  output logic        resp_valid,
  output logic [7:0]  resp_code,
  output logic [15:0] resp_id
);
  localparam int TW = ($clog2(TIMEOUT + 1) > 11) ? $clog2(TIMEOUT + 1) : 11;
  typedef enum logic [2:0] {IDLE, RECV, CHECK, ISSUE_ADD, ISSUE_CXL, RELEASE, RESP} state_t;
  state_t state, state_nx;
  logic [2:0] cnt;
  logic [TW-1:0] idle;
  logic is_add;
  logic [7:0] side;
  logic [15:0] id, px, qty;
  logic acc, op_ok, last, bad, tmo;
  assign in_ready = (state == IDLE) || (state == RECV);
  assign add_start = state == ISSUE_ADD;
  assign cxl_start = state == ISSUE_CXL;
  assign resp_valid = state == RESP;
  assign acc = in_valid & in_ready;
  assign op_ok = (in_byte == 8'h41) || (in_byte == 8'h58);
  assign last = is_add ? (cnt == 3'd7) : (cnt == 3'd2);
  assign bad = (id == 16'hFFFF) || (is_add && ((side > 8'd1) || (qty == 16'd0)));
  assign tmo = (state == RECV) && !acc && (idle == TW'(TIMEOUT - 1));
  // State register; async reset drops any held start immediately
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      state_nx = acc ? (op_ok ? RECV : RESP) : IDLE;
      RECV:      state_nx = (acc && last) ? CHECK : (tmo ? RESP : RECV);
      CHECK:     state_nx = bad ? RESP : (is_add ? ISSUE_ADD : ISSUE_CXL);
      ISSUE_ADD: state_nx = add_done ? RELEASE : ISSUE_ADD;
      ISSUE_CXL: state_nx = cxl_done ? RELEASE : ISSUE_CXL;
      RELEASE:   state_nx = (is_add ? add_done : cxl_done) ? RELEASE : RESP;
      RESP:      state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end
  // Message capture: byte index, idle counter and big-endian field assembly
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt <= '0;
      idle <= '0;
      is_add <= 1'b0;
      side <= '0;
      id <= '0;
      px <= '0;
      qty <= '0;
    end else if (state == IDLE && acc) begin
      is_add <= in_byte == 8'h41;
      cnt <= 3'd1;
      idle <= '0;
      side <= '0;
      id <= '0;
      px <= '0;
      qty <= '0;
    end else if (state == RECV && acc) begin
      cnt <= cnt + 3'd1;
      idle <= '0;
      if (is_add)
        case (cnt)
          3'd1: side <= in_byte;
          3'd2: id[15:8] <= in_byte;
          3'd3: id[7:0] <= in_byte;
          3'd4: px[15:8] <= in_byte;
          3'd5: px[7:0] <= in_byte;
          3'd6: qty[15:8] <= in_byte;
          3'd7: qty[7:0] <= in_byte;
          default: ;
        endcase
      else if (cnt == 3'd1) id[15:8] <= in_byte;
      else id[7:0] <= in_byte;
    end else if (state == RECV) idle <= idle + TW'(1);
  // Engine-facing fields and response code/id
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      add_side <= 1'b0;
      add_order <= '0;
      cxl_id <= '0;
      resp_code <= '0;
      resp_id <= '0;
    end else
      case (state)
        IDLE: if (acc && !op_ok) begin
          resp_code <= 8'h03;
          resp_id <= '0;
        end
        RECV: if (tmo) begin
          resp_code <= 8'h05;
          resp_id <= id;
        end
        CHECK: begin
          add_side <= side[0];
          add_order <= {id, px, qty};
          cxl_id <= id;
          resp_code <= 8'h04;
          resp_id <= id;
        end
        ISSUE_ADD: if (add_done) resp_code <= (add_success == 16'd1) ? 8'h00 : 8'h02;
        ISSUE_CXL: if (cxl_done) resp_code <= (cxl_success == 16'd1) ? 8'h00 : 8'h01;
        default: ;
      endcase
endmodule

// File: tb/tb_order_msg_dispatcher.sv
// tb_order_msg_dispatcher: table vectors, hand corner sequences and random messages against a message-level model
module tb_order_msg_dispatcher;
  logic clk = 0;
  logic rst = 0;
  logic [7:0] in_byte = 0;
  logic in_valid = 0;
  logic in_ready, add_start, add_side, cxl_start, resp_valid;
  logic [47:0] add_order;
  logic add_done, cxl_done;
  logic [15:0] add_success, cxl_success, cxl_id, resp_id;
  logic [7:0] resp_code;
  always #5 clk = ~clk;
  order_msg_dispatcher dut (
    .clk(clk), .rst(rst), .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
    .add_start(add_start), .add_side(add_side), .add_order(add_order), .add_done(add_done),
    .add_success(add_success), .cxl_start(cxl_start), .cxl_id(cxl_id), .cxl_done(cxl_done),
    .cxl_success(cxl_success), .resp_valid(resp_valid), .resp_code(resp_code), .resp_id(resp_id)
  );
  typedef struct {
    logic [63:0] msg;
    int len;
    logic [15:0] succ;
    logic [7:0] code;
    logic [15:0] id;
  } vec_t;
  vec_t vec[10];
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_code_q[$];
  logic [15:0] exp_id_q[$];
  int n_resp = 0;
  int n_add = 0;
  int n_cxl = 0;
  logic prev_add = 0;
  logic prev_cxl = 0;
  logic [15:0] succ_val = 0;
  int eng_dly = 0;
  bit eng_en = 1;
  logic exp_side = 0;
  logic [47:0] exp_order = 0;
  logic [15:0] exp_cid = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s", nm);
  endtask
  function automatic logic [23:0] model(input logic [63:0] m, input logic [15:0] s);
    logic [7:0] op;
    logic [15:0] id;
    op = m[63:56];
    if (op == 8'h41) begin
      id = m[47:32];
      if (m[55:48] > 8'd1 || id == 16'hFFFF || m[15:0] == 16'd0) return {8'h04, id};
      return {(s == 16'd1) ? 8'h00 : 8'h02, id};
    end
    if (op == 8'h58) begin
      id = m[55:40];
      if (id == 16'hFFFF) return {8'h04, id};
      return {(s == 16'd1) ? 8'h00 : 8'h01, id};
    end
    return {8'h03, 16'h0000};
  endfunction
  // Engine stand-in: raises done after a delay while start is high, drops it after start falls
  initial begin
    add_done = 0;
    cxl_done = 0;
    add_success = 0;
    cxl_success = 0;
    forever begin
      @(negedge clk);
      if (eng_en && add_start && !add_done) begin
        repeat (eng_dly) @(negedge clk);
        add_success = succ_val;
        add_done = 1;
      end else if (!add_start && add_done) begin
        repeat (eng_dly) @(negedge clk);
        add_done = 0;
      end
      if (eng_en && cxl_start && !cxl_done) begin
        repeat (eng_dly) @(negedge clk);
        cxl_success = succ_val;
        cxl_done = 1;
      end else if (!cxl_start && cxl_done) begin
        repeat (eng_dly) @(negedge clk);
        cxl_done = 0;
      end
    end
  end
  // Monitor: start exclusivity, fields at start rise, response scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      prev_add = 0;
      prev_cxl = 0;
    end else begin
      if (add_start && cxl_start) fail("start_exclusive");
      if (add_start && !prev_add) begin
        n_add++;
        chk("add_side", add_side, exp_side);
        chk("add_order", add_order, exp_order);
      end
      if (cxl_start && !prev_cxl) begin
        n_cxl++;
        chk("cxl_id", cxl_id, exp_cid);
      end
      prev_add = add_start;
      prev_cxl = cxl_start;
      if (resp_valid) begin
        n_resp++;
        if (exp_code_q.size() == 0) fail("unexpected_resp");
        else begin
          chk("resp_code", resp_code, exp_code_q.pop_front());
          chk("resp_id", resp_id, exp_id_q.pop_front());
        end
      end
    end
  end
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_valid = 1;
    in_byte = b;
    while (!in_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) fail("in_ready_timeout");
    @(negedge clk);
    in_valid = 0;
  endtask
  task automatic wait_resp(input int r0, input int bound);
    int t = 0;
    while (n_resp == r0 && t < bound) begin
      @(negedge clk);
      t++;
    end
    if (n_resp == r0) fail("resp_wait_timeout");
  endtask
  task automatic run_msg(input logic [63:0] msg, input int len, input logic [15:0] succ,
                         input logic [7:0] code, input logic [15:0] id, input int gap);
    int ea, ec, a0, c0, r0;
    ea = (code <= 8'h02 && msg[63:56] == 8'h41) ? 1 : 0;
    ec = (code <= 8'h02 && msg[63:56] == 8'h58) ? 1 : 0;
    exp_side = msg[48];
    exp_order = msg[47:0];
    exp_cid = msg[55:40];
    succ_val = succ;
    eng_dly = $urandom_range(0, 3);
    exp_code_q.push_back(code);
    exp_id_q.push_back(id);
    a0 = n_add;
    c0 = n_cxl;
    r0 = n_resp;
    for (int i = 0; i < len; i++) begin
      send_byte(msg[63-8*i -: 8]);
      if (i < len - 1) repeat ((gap < 0) ? $urandom_range(0, 2) : gap) @(negedge clk);
    end
    if (len == 1) chk("badop_latency", {63'd0, resp_valid}, 1);
    wait_resp(r0, 300);
    chk("add_starts", n_add - a0, ea);
    chk("cxl_starts", n_cxl - c0, ec);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    logic [63:0] m;
    logic [23:0] e;
    logic [15:0] s;
    logic [7:0] b;
    int r0, t;
    vec[0] = '{64'h5800070000000000, 3, 16'h0001, 8'h00, 16'h0007};
    vec[1] = '{64'h410112340064000A, 8, 16'h0000, 8'h02, 16'h1234};
    vec[2] = '{64'h7F00000000000000, 1, 16'h0001, 8'h03, 16'h0000};
    vec[3] = '{64'h5800070000000000, 3, 16'h0001, 8'h00, 16'h0007};
    vec[4] = '{64'h58FFFF0000000000, 3, 16'h0001, 8'h04, 16'hFFFF};
    vec[5] = '{64'h4100000500100000, 8, 16'h0001, 8'h04, 16'h0005};
    vec[6] = '{64'h4102000500100001, 8, 16'h0001, 8'h04, 16'h0005};
    vec[7] = '{64'h5800090000000000, 3, 16'h0002, 8'h01, 16'h0009};
    vec[8] = '{64'h4100ABCD01000001, 8, 16'h0001, 8'h00, 16'hABCD};
    vec[9] = '{64'h4100FFFF00010001, 8, 16'h0001, 8'h04, 16'hFFFF};
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {63'd0, in_ready}, 1);
    chk("rst_ctrl", {60'd0, add_start, cxl_start, resp_valid, add_side}, 0);
    chk("rst_order", add_order, 0);
    chk("rst_resp", {resp_code, resp_id, cxl_id}, 0);
    rst = 1;
    @(negedge clk);
    exp_cid = 16'h0007;
    succ_val = 16'h0001;
    eng_dly = 0;
    exp_code_q.push_back(8'h00);
    exp_id_q.push_back(16'h0007);
    r0 = n_resp;
    send_byte(8'h58);
    send_byte(8'h00);
    send_byte(8'h07);
    chk("start_not_in_check", {63'd0, cxl_start}, 0);
    @(negedge clk);
    chk("start_after_check", {63'd0, cxl_start}, 1);
    wait_resp(r0, 300);
    for (int i = 0; i < 10; i++) run_msg(vec[i].msg, vec[i].len, vec[i].succ, vec[i].code, vec[i].id, -1);
    run_msg(64'h5800070000000000, 3, 16'h0001, 8'h00, 16'h0007, 999);
    exp_code_q.push_back(8'h05);
    exp_id_q.push_back(16'h0000);
    r0 = n_resp;
    send_byte(8'h58);
    send_byte(8'h00);
    wait_resp(r0, 1100);
    @(negedge clk);
    chk("timeout_idle_ready", {63'd0, in_ready}, 1);
    run_msg(64'h5800420000000000, 3, 16'h0001, 8'h00, 16'h0042, 0);
    eng_en = 0;
    exp_cid = 16'h0033;
    r0 = n_resp;
    send_byte(8'h58);
    send_byte(8'h00);
    send_byte(8'h33);
    t = 0;
    while (!cxl_start && t < 10) begin
      @(negedge clk);
      t++;
    end
    chk("cxl_start_before_rst", {63'd0, cxl_start}, 1);
    #2 rst = 0;
    #1 chk("cxl_start_async_drop", {63'd0, cxl_start}, 0);
    chk("rst_idle_ready", {63'd0, in_ready}, 1);
    repeat (2) @(negedge clk);
    rst = 1;
    eng_en = 1;
    repeat (5) @(negedge clk);
    chk("no_resp_after_rst", n_resp, r0);
    for (int k = 0; k < 40; k++) begin
      t = $urandom_range(0, 9);
      s = ($urandom_range(0, 1) == 1) ? 16'h0001 : 16'($urandom);
      if (t == 0) begin
        b = 8'($urandom);
        while (b == 8'h41 || b == 8'h58) b = 8'($urandom);
        m = {b, 56'd0};
        e = model(m, s);
        run_msg(m, 1, s, e[23:16], e[15:0], -1);
      end else if (t <= 5) begin
        m = {8'h41, ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'($urandom_range(0, 1)),
             ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom), 16'($urandom),
             ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom)};
        e = model(m, s);
        run_msg(m, 8, s, e[23:16], e[15:0], -1);
      end else begin
        m = {8'h58, ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom), 40'd0};
        e = model(m, s);
        run_msg(m, 3, s, e[23:16], e[15:0], -1);
      end
    end
    repeat (5) @(negedge clk);
    chk("resp_queue_drained", exp_code_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/order_msg_dispatcher.md
# order_msg_dispatcher

Front-end stage of the limit order book: assembles incoming byte-serial order messages, validates them, and issues each one to the add-order or execute/cancel engine over a level-held start/done handshake. It sits between the host byte link and the book engines. For every message it produces exactly one response: a completion, a rejection, or a timeout.

## Interface
- TIMEOUT, 1000: idle cycles allowed between bytes of a partial message before it is dropped (≥2).
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_byte  in  8  message byte.
- in_valid  in  1  in_byte valid.
- in_ready  out  1  dispatcher accepts a byte this cycle.
- add_start  out  1  add request, level-held.
- add_side  out  1  0 = buy, 1 = sell.
- add_order  out  48  order word: [47:32] id, [31:16] price, [15:0] qty.
- add_done  in  1  add engine finished.
- add_success  in  16  16'd1 = inserted; any other value = rejected (book full).
- cxl_start  out  1  cancel request, level-held.
- cxl_id  out  16  order id to cancel.
- cxl_done  in  1  cancel engine finished.
- cxl_success  in  16  16'd1 = found and deleted.
- resp_valid  out  1  one-cycle response pulse.
- resp_code  out  8  response code.
- resp_id  out  16  id of the message the response refers to.

## Operation
- Byte transfer: a byte is accepted on a rising edge with in_valid & in_ready.
- Message formats, multi-byte fields big-endian:
  - ADD: 0x41, side, id_hi, id_lo, px_hi, px_lo, qty_hi, qty_lo (8 bytes).
  - CANCEL: 0x58, id_hi, id_lo (3 bytes).
- States:
  - IDLE: in_ready=1. Opcode 0x41 or 0x58 → RECV with byte count 1. Any other byte → RESP, code 0x03, resp_id 0.
  - RECV: in_ready=1. Stores bytes and counts them. On the final byte, goes to CHECK.
  - CHECK: in_ready=0, one cycle.
    - Invalid fields → RESP, code 0x04. Invalid means: ADD with side > 1, id = 0xFFFF, or qty = 0; CANCEL with id = 0xFFFF. (0xFFFF id and the all-ones word mark deleted book entries; qty 0 keeps the word nonzero so it is never mistaken for an empty slot.)
    - Otherwise → ISSUE_ADD or ISSUE_CXL.
  - ISSUE_ADD / ISSUE_CXL: the matching start is held at 1 with the order/id fields stable. The state waits for the matching done=1, then latches success and goes to RELEASE.
  - RELEASE: start=0. Waits for the matching done=0, then goes to RESP. This mirrors the engines, which return to idle only after start falls.
  - RESP: resp_valid=1 for one cycle, then IDLE.
- Response codes:
  - 0x00: success==16'd1.
  - 0x01: cancel id not found.
  - 0x02: add rejected.
  - 0x03: bad opcode.
  - 0x04: invalid field.
  - 0x05: timeout.
- Timeout: an 11+ bit idle counter runs in RECV only. It clears on every accepted byte and on entry to RECV. When it reaches TIMEOUT, the partial message is dropped and the block goes to RESP with code 0x05 and resp_id = id bytes received so far (0 if none).
- Only one engine is started per message; add_start and cxl_start are never high together.
- add_order, add_side and cxl_id hold their values until the next message reaches CHECK.

## Timing
- Reset: all outputs 0 except in_ready, which is 1 (IDLE). Partial message and counters cleared. Reset during ISSUE or RELEASE drops start immediately, asynchronously.
- Start rises on the first edge after CHECK, i.e. 2 cycles after the final byte is accepted.
- success is sampled on the edge where done is first seen high, and start falls on that edge.
- Response latency after done falls: RESP is entered on the edge where done=0 is seen; resp_valid is high the following cycle.
- Minimum message-to-message spacing is bounded by the engine handshake. No byte is accepted from CHECK through RESP; upstream must hold in_valid.
- done already high on entry to ISSUE: it is treated as the finish of the current request only after start has been high for at least one edge.

## Test plan
- CANCEL 58 00 07 with the engine returning success=1 → cxl_start high, cxl_id=0x0007; after done, resp_code 0x00, resp_id 0x0007, exactly one resp_valid.
- ADD 41 01 12 34 00 64 00 0A → add_side=1, add_order=0x1234_0064_000A; engine success=0 → resp_code 0x02, resp_id 0x1234.
- Byte 0x7F in IDLE → resp_code 0x03 next cycle; following valid CANCEL processed normally.
- CANCEL 58 FF FF → no cxl_start, resp_code 0x04; ADD with qty=0 → code 0x04.
- CANCEL 58 00 then silence for TIMEOUT cycles → resp_code 0x05, resp_id 0x0000, back in IDLE with in_ready=1.
- Reset asserted while cxl_start high → cxl_start 0 asynchronously; after release, IDLE and no resp_valid.
